mem_write_controller: RTL and testbench
=======================================

Name: mem_write_controller

Overview:
Store-path counterpart of the load data path in the riscv_core memory stage. It decodes store instructions and the effective address, then generates byte write-enables and lane-aligned write data for DMEM and IMEM. It buffers UART transmit bytes in a small FIFO drained over a valid/ready handshake, and issues the cycle-counter reset pulse. It asserts a stall back to the pipeline only when the UART TX FIFO is full.

Parameters:
DMEM_AW, 14, DMEM word-address width
IMEM_AW, 14, IMEM word-address width
TX_DEPTH, 4, UART TX FIFO depth (power of 2, >=2)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
instruction  input  32  instruction in memory stage (opcode [6:0], funct3 [14:12])
mem_en  input  1  stage valid (not flushed/bubble)
mem_addr  input  32  effective byte address
store_data  input  32  rs2 value
imem_wr_allow  input  1  IMEM writes permitted (PC executing from BIOS)
dmem_we  output  4  DMEM byte write-enables
dmem_addr  output  DMEM_AW  mem_addr[DMEM_AW+1:2]
dmem_din  output  32  lane-aligned DMEM write data
imem_we  output  4  IMEM byte write-enables
imem_addr  output  IMEM_AW  mem_addr[IMEM_AW+1:2]
imem_din  output  32  same as dmem_din
uart_tx_valid  output  1  FIFO head valid toward UART transmitter
uart_tx_data  output  8  FIFO head byte
uart_tx_ready  input  1  UART transmitter accepts byte
tx_fifo_full  output  1  status, for UART control register read
tx_fifo_empty  output  1  status
cycle_counter_rst  output  1  one-cycle reset pulse to cycle counter
stall  output  1  hold memory stage; store not yet accepted

Behaviour:
- A store is active when mem_en=1 and opcode=OPC_STORE. When a store is not active, all write-enables are 0, there is no FIFO push, and there is no pulse.
- Lane rules (off = mem_addr[1:0]):
  - SB: we=1<<off; din={4{store_data[7:0]}}.
  - SH: off 0->0011, 1->0110, 2->1100, each with din=store_data<<(8*off). off 3->0011 with din unshifted, matching the load side's low-halfword convention.
  - SW: we=1111, din=store_data, regardless of off.
  - Unknown funct3: no write.
- Address decode on mem_addr[31:28]:
  - 0001 -> DMEM.
  - 0010 -> IMEM.
  - 0011 -> both.
  - IMEM write-enables are forced to 0 when imem_wr_allow=0.
  - 0100 (BIOS) -> ignored.
  - 1000 with mem_addr[7:0]=0x08 -> UART TX push of store_data[7:0], for any store width.
  - 1000 with mem_addr[7:0]=0x18 -> cycle-counter reset.
  - All other addresses are ignored, with no error.
- Memory write outputs are combinational from the inputs. The memories capture them at the clk edge.
- UART TX FIFO:
  - TX_DEPTH entries, with read/write pointers and a count. Full/empty derive from the registered count.
  - uart_tx_valid = !empty; uart_tx_data = head entry, held stable while valid && !ready.
  - Pop on valid && ready.
  - Push on a UART store when !full.
  - stall = UART store && full, combinational. While stalled there is no push; the pipeline holds the instruction and retries next cycle.
  - A pop in the same cycle as a full-state store does not clear stall that cycle; the push lands next cycle.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - Pointers wrap modulo TX_DEPTH.
  - Bytes exit in push order.
- cycle_counter_rst is registered: high for exactly one cycle, the cycle after the store's edge.
- Reset values: pointers=0, count=0, uart_tx_valid=0, tx_fifo_empty=1, tx_fifo_full=0, cycle_counter_rst=0. Reset mid-operation discards all buffered bytes.
- Write-enables and stall are 0 whenever no store is active, including during rst.

Test Plan:
- SB, addr 0x10000003, data 0x000000AB -> dmem_we=1000, dmem_din=0xABABABAB, dmem_addr=0, imem_we=0000.
- SH, addr 0x10000006, data 0x00001234 -> dmem_we=1100, din=0x12340000. SH, addr 0x10000007 -> we=0011, din=0x00001234.
- SW, addr 0x30000010, data 0xDEADBEEF, imem_wr_allow=1 -> dmem_we=imem_we=1111, both addr=4, din=0xDEADBEEF. Same with imem_wr_allow=0 -> imem_we=0000.
- uart_tx_ready=0, five SB to 0x80000008 with 0x41..0x45:
  - first four accepted, stall=0, tx_fifo_full=1;
  - fifth: stall=1 held;
  - ready pulsed 1 cycle -> 0x41 popped, fifth accepted next cycle;
  - ready=1 -> bytes 0x42,0x43,0x44,0x45 emerge in order, then empty=1, valid=0.
- SW to 0x80000018 -> cycle_counter_rst=1 for exactly the next cycle. Store to 0x40000000 -> no enables, no push.
- Three bytes buffered, rst asserted one cycle mid-drain -> next cycle: empty=1, uart_tx_valid=0, count 0. A subsequent push of 0x5A emerges first.

Source files
------------

// File: rtl/mem_write_controller.sv
// ---------------------------------------------------------------------------
// mem_write_controller
//
// Store path of the memory stage. Decodes store instructions and the
// effective address, then produces byte write-enables and lane-aligned write
// data for DMEM and IMEM. Buffers UART transmit bytes in a small FIFO that
// drains over a valid/ready handshake. Issues a one-cycle cycle-counter
// reset pulse. Raises stall only when a UART store meets a full FIFO.
//
// Ports
//   clk, rst           core clock; synchronous active-high reset
//   instruction        memory-stage instruction (opcode [6:0], funct3 [14:12])
//   mem_en             stage valid (not flushed / bubble)
//   mem_addr           effective byte address
//   store_data         rs2 value
//   imem_wr_allow      IMEM writes permitted (executing from BIOS)
//   dmem_we/addr/din   DMEM byte enables, word address, write data
//   imem_we/addr/din   IMEM byte enables, word address, write data
//   uart_tx_valid/data FIFO head toward the UART transmitter
//   uart_tx_ready      transmitter accepts the head byte
//   tx_fifo_full/empty FIFO status for the UART control register
//   cycle_counter_rst  one-cycle pulse, the cycle after the store's edge
//   stall              hold the memory stage; UART store not yet accepted
// ---------------------------------------------------------------------------
module mem_write_controller #(
    parameter int DMEM_AW  = 14,
    parameter int IMEM_AW  = 14,
    parameter int TX_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               mem_en,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        store_data,
    input  logic               imem_wr_allow,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    output logic [3:0]         imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_din,
    output logic               uart_tx_valid,
    output logic [7:0]         uart_tx_data,
    input  logic               uart_tx_ready,
    output logic               tx_fifo_full,
    output logic               tx_fifo_empty,
    output logic               cycle_counter_rst,
    output logic               stall
);

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;

    localparam int               PTR_W    = $clog2(TX_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TX_DEPTH);

    // ---------------------------------------------------------------- decode
    logic        store_active;
    logic [1:0]  off;
    logic [3:0]  region;
    logic [3:0]  lane_we;
    logic [31:0] lane_din;
    logic        is_dmem;
    logic        is_imem;
    logic        uart_store;
    logic        cnt_store;

    assign store_active = mem_en && (instruction[6:0] == OPC_STORE);
    assign off          = mem_addr[1:0];
    assign region       = mem_addr[31:28];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        lane_we  = 4'b0000;
        lane_din = store_data;
        case (instruction[14:12])
            F3_SB: begin
                lane_we  = 4'b0001 << off;
                lane_din = {4{store_data[7:0]}};
            end
            F3_SH: begin
                // A halfword at offset 3 would straddle words; it falls back
                // to the low halfword, mirroring the load side.
                if (off == 2'd3) begin
                    lane_we = 4'b0011;
                end else begin
                    lane_we  = 4'b0011 << off;
                    lane_din = store_data << {off, 3'b000};
                end
            end
            F3_SW:   lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
        if (!store_active) begin
            lane_we = 4'b0000;
        end
    end

    assign is_dmem    = (region == 4'h1) || (region == 4'h3);
    assign is_imem    = ((region == 4'h2) || (region == 4'h3)) && imem_wr_allow;
    assign uart_store = store_active && (region == 4'h8) && (mem_addr[7:0] == 8'h08);
    assign cnt_store  = store_active && (region == 4'h8) && (mem_addr[7:0] == 8'h18);

    assign dmem_we   = is_dmem ? lane_we : 4'b0000;
    assign imem_we   = is_imem ? lane_we : 4'b0000;
    assign dmem_addr = mem_addr[DMEM_AW+1:2];
    assign imem_addr = mem_addr[IMEM_AW+1:2];
    assign dmem_din  = lane_din;
    assign imem_din  = lane_din;

    // ------------------------------------------------------------ UART TX FIFO
    logic [7:0]       fifo_q [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic             cc_rst_q;

    assign tx_fifo_full  = (count_q == CNT_FULL);
    assign tx_fifo_empty = (count_q == '0);

    // Full is judged on the registered count, so a pop in the same cycle
    // does not release a stalled store until the following cycle.
    assign push  = uart_store && !tx_fifo_full;
    assign pop   = !tx_fifo_empty && uart_tx_ready;
    assign stall = uart_store && tx_fifo_full;

    assign uart_tx_valid = !tx_fifo_empty;
    assign uart_tx_data  = fifo_q[rd_ptr_q];

    // Power-of-two depth: pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cc_rst_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cc_rst_q <= cnt_store;
        end
    end

    // NOTE: the storage array is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= store_data[7:0];
        end
    end

    assign cycle_counter_rst = cc_rst_q;

    // Only slices of these buses are decoded; fold the rest into one sink.
    logic unused_ok;
    assign unused_ok = ^{instruction, mem_addr};

endmodule

// File: tb/tb_mem_write_controller.sv
// ---------------------------------------------------------------------------
// tb_mem_write_controller
//
// Directed scenarios with literal expectations, followed by randomized
// stimulus. A queue-based reference model tracks the UART FIFO contents and
// the cycle-counter pulse; a compare process checks every DUT output against
// it on each falling edge.
// ---------------------------------------------------------------------------
module tb_mem_write_controller;

    localparam int DMEM_AW  = 14;
    localparam int IMEM_AW  = 14;
    localparam int TX_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        instruction;
    logic               mem_en;
    logic [31:0]        mem_addr;
    logic [31:0]        store_data;
    logic               imem_wr_allow;
    logic [3:0]         dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_din;
    logic [3:0]         imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_din;
    logic               uart_tx_valid;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_ready;
    logic               tx_fifo_full;
    logic               tx_fifo_empty;
    logic               cycle_counter_rst;
    logic               stall;

    mem_write_controller #(
        .DMEM_AW (DMEM_AW),
        .IMEM_AW (IMEM_AW),
        .TX_DEPTH(TX_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .instruction      (instruction),
        .mem_en           (mem_en),
        .mem_addr         (mem_addr),
        .store_data       (store_data),
        .imem_wr_allow    (imem_wr_allow),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_din         (dmem_din),
        .imem_we          (imem_we),
        .imem_addr        (imem_addr),
        .imem_din         (imem_din),
        .uart_tx_valid    (uart_tx_valid),
        .uart_tx_data     (uart_tx_data),
        .uart_tx_ready    (uart_tx_ready),
        .tx_fifo_full     (tx_fifo_full),
        .tx_fifo_empty    (tx_fifo_empty),
        .cycle_counter_rst(cycle_counter_rst),
        .stall            (stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------- reference model
    logic [7:0] q[$];
    logic       exp_cc = 1'b0;
    logic       model_live = 1'b0;

    // Expected combinational store decode, straight from the lane/address rules.
    function automatic void model_comb(output logic [3:0] dwe, output logic [3:0] iwe,
                                       output logic [31:0] din, output logic [3:0] lane,
                                       output logic uart, output logic cnt);
        logic       act;
        int         o;
        int         rgn;
        act  = mem_en && (instruction[6:0] == 7'h23);
        o    = int'(mem_addr[1:0]);
        rgn  = int'(mem_addr[31:28]);
        lane = 4'b0000;
        din  = 32'h0;
        if (act) begin
            case (instruction[14:12])
                3'd0: begin
                    lane = 4'(1 << o);
                    din  = store_data[7:0] * 32'h01010101;
                end
                3'd1: begin
                    if (o == 3) begin
                        lane = 4'b0011;
                        din  = store_data;
                    end else begin
                        lane = 4'(3 << o);
                        din  = store_data * (32'h1 << (8 * o));
                    end
                end
                3'd2: begin
                    lane = 4'b1111;
                    din  = store_data;
                end
                default: lane = 4'b0000;
            endcase
        end
        dwe  = (rgn == 1 || rgn == 3) ? lane : 4'b0000;
        iwe  = ((rgn == 2 || rgn == 3) && imem_wr_allow) ? lane : 4'b0000;
        uart = act && rgn == 8 && mem_addr[7:0] == 8'h08;
        cnt  = act && rgn == 8 && mem_addr[7:0] == 8'h18;
    endfunction

    always @(posedge clk) begin
        logic [3:0]  dwe, iwe, lane;
        logic [31:0] din;
        logic        uart, cnt, do_pop, do_push;
        if (rst) begin
            q.delete();
            exp_cc = 1'b0;
        end else begin
            model_comb(dwe, iwe, din, lane, uart, cnt);
            do_pop  = (q.size() > 0) && uart_tx_ready;
            do_push = uart && (q.size() < TX_DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(store_data[7:0]);
            exp_cc = cnt;
        end
    end

    always @(negedge clk) begin
        logic [3:0]  dwe, iwe, lane;
        logic [31:0] din;
        logic        uart, cnt;
        if (model_live) begin
            model_comb(dwe, iwe, din, lane, uart, cnt);
            check("m_dmem_we", dmem_we, dwe);
            check("m_imem_we", imem_we, iwe);
            if (lane != 4'b0000) begin
                check("m_dmem_din", dmem_din, din);
                check("m_imem_din", imem_din, din);
            end
            check("m_dmem_addr", dmem_addr, mem_addr[DMEM_AW+1:2]);
            check("m_imem_addr", imem_addr, mem_addr[IMEM_AW+1:2]);
            check("m_valid", uart_tx_valid, q.size() != 0);
            if (q.size() != 0) check("m_data", uart_tx_data, q[0]);
            check("m_full", tx_fifo_full, q.size() == TX_DEPTH);
            check("m_empty", tx_fifo_empty, q.size() == 0);
            check("m_stall", stall, uart && q.size() == TX_DEPTH);
            check("m_cc_rst", cycle_counter_rst, exp_cc);
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        mem_en      = 1'b1;
        instruction = {17'h0, f3, 5'h0, 7'h23};
        mem_addr    = addr;
        store_data  = data;
    endtask

    task automatic idle();
        mem_en      = 1'b0;
        instruction = 32'h0000_0013;
    endtask

    initial begin
        rst           = 1'b1;
        instruction   = 32'h0000_0013;
        mem_en        = 1'b0;
        mem_addr      = 32'h0;
        store_data    = 32'h0;
        imem_wr_allow = 1'b0;
        uart_tx_ready = 1'b0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", uart_tx_valid, 1'b0);
        check("rst_empty", tx_fifo_empty, 1'b1);
        check("rst_full", tx_fifo_full, 1'b0);
        check("rst_cc", cycle_counter_rst, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_dmem_we", dmem_we, 4'b0000);
        model_live = 1'b1;

        tick();
        rst = 1'b0;

        // Byte / halfword / word lanes
        tick();
        set_store(3'd0, 32'h1000_0003, 32'h0000_00AB);
        @(negedge clk);
        check("sb_dmem_we", dmem_we, 4'b1000);
        check("sb_dmem_din", dmem_din, 32'hABAB_ABAB);
        check("sb_dmem_addr", dmem_addr, 0);
        check("sb_imem_we", imem_we, 4'b0000);

        tick();
        set_store(3'd1, 32'h1000_0006, 32'h0000_1234);
        @(negedge clk);
        check("sh6_dmem_we", dmem_we, 4'b1100);
        check("sh6_dmem_din", dmem_din, 32'h1234_0000);

        tick();
        set_store(3'd1, 32'h1000_0007, 32'h0000_1234);
        @(negedge clk);
        check("sh7_dmem_we", dmem_we, 4'b0011);
        check("sh7_dmem_din", dmem_din, 32'h0000_1234);

        tick();
        imem_wr_allow = 1'b1;
        set_store(3'd2, 32'h3000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_dmem_we", dmem_we, 4'b1111);
        check("sw_imem_we", imem_we, 4'b1111);
        check("sw_dmem_addr", dmem_addr, 4);
        check("sw_imem_addr", imem_addr, 4);
        check("sw_din", imem_din, 32'hDEAD_BEEF);

        tick();
        imem_wr_allow = 1'b0;
        @(negedge clk);
        check("sw_noallow_imem_we", imem_we, 4'b0000);
        check("sw_noallow_dmem_we", dmem_we, 4'b1111);

        tick();
        set_store(3'd3, 32'h1000_0000, 32'h1111_1111);
        @(negedge clk);
        check("bad_f3_dmem_we", dmem_we, 4'b0000);

        // UART FIFO fill, stall, release, drain
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            set_store(3'd0, 32'h8000_0008, 32'h41 + i);
            @(negedge clk);
            check("fill_stall", stall, 1'b0);
        end
        tick();
        set_store(3'd0, 32'h8000_0008, 32'h45);
        @(negedge clk);
        check("fill_full", tx_fifo_full, 1'b1);
        check("fifth_stall", stall, 1'b1);
        tick();
        @(negedge clk);
        check("fifth_stall_held", stall, 1'b1);
        check("head_41", uart_tx_data, 8'h41);
        tick();
        uart_tx_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_stall", stall, 1'b1);
        tick();
        uart_tx_ready = 1'b0;
        @(negedge clk);
        check("after_pop_stall", stall, 1'b0);
        check("after_pop_head", uart_tx_data, 8'h42);
        tick();
        idle();
        @(negedge clk);
        check("refill_full", tx_fifo_full, 1'b1);
        tick();
        uart_tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_valid", uart_tx_valid, 1'b1);
            check("drain_data", uart_tx_data, 8'h42 + k);
            tick();
        end
        @(negedge clk);
        check("drain_empty", tx_fifo_empty, 1'b1);
        check("drain_valid_low", uart_tx_valid, 1'b0);

        // Cycle counter pulse, ignored BIOS region
        tick();
        set_store(3'd2, 32'h8000_0018, 32'h0);
        @(negedge clk);
        check("cc_before", cycle_counter_rst, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check("cc_pulse", cycle_counter_rst, 1'b1);
        tick();
        @(negedge clk);
        check("cc_after", cycle_counter_rst, 1'b0);

        tick();
        imem_wr_allow = 1'b1;
        set_store(3'd2, 32'h4000_0000, 32'h1234_5678);
        @(negedge clk);
        check("bios_dmem_we", dmem_we, 4'b0000);
        check("bios_imem_we", imem_we, 4'b0000);
        tick();
        idle();
        @(negedge clk);
        check("bios_no_push", tx_fifo_empty, 1'b1);

        // Reset mid-drain discards buffered bytes
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_store(3'd0, 32'h8000_0008, 32'h11 * (i + 1));
        end
        tick();
        idle();
        uart_tx_ready = 1'b1;
        @(negedge clk);
        check("pre_rst_head", uart_tx_data, 8'h11);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        uart_tx_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_empty", tx_fifo_empty, 1'b1);
        check("mid_rst_valid", uart_tx_valid, 1'b0);
        tick();
        set_store(3'd0, 32'h8000_0008, 32'h5A);
        tick();
        idle();
        @(negedge clk);
        check("post_rst_valid", uart_tx_valid, 1'b1);
        check("post_rst_head", uart_tx_data, 8'h5A);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            logic [31:0] ins;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            a = $urandom;
            case ($urandom_range(0, 7))
                0: a[31:28] = 4'h1;
                1: a[31:28] = 4'h2;
                2: a[31:28] = 4'h3;
                3: a[31:28] = 4'h4;
                4, 5, 6: begin
                    a[31:28] = 4'h8;
                    case ($urandom_range(0, 3))
                        0, 1: a[7:0] = 8'h08;
                        2:    a[7:0] = 8'h18;
                        default: a[7:0] = 8'($urandom);
                    endcase
                end
                default: a[31:28] = 4'($urandom);
            endcase
            ins = $urandom;
            ins[6:0]   = ($urandom_range(0, 4) != 0) ? 7'h23 : 7'h03;
            ins[14:12] = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            instruction   = ins;
            mem_addr      = a;
            store_data    = $urandom;
            mem_en        = ($urandom_range(0, 9) != 0);
            imem_wr_allow = $urandom_range(0, 1) == 1;
            uart_tx_ready = ($urandom_range(0, 2) == 0);
        end

        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        model_live = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
